// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the block-RAM stream reader and its response buffer.
// The response entry pairs a RAM word with the request tag it answers.
package bram_stream_reader_pkg;

    localparam int unsigned DEF_MEM_SIZE   = 5;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TAG_WIDTH  = 4;

    // Read latencies the RAM macro can be configured for.
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_TAG_WIDTH-1:0]  tag;
    } rsp_t;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/small_sync_fifo.sv
// Small single-clock first-word-fall-through FIFO with occupancy count.
// The head entry is presented on pop_data whenever count is non-zero; push and pop may coincide.
module small_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !do_push))
            else $error("small_sync_fifo: push dropped, FIFO overflow");
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side client for the one-clock block RAM: request stream in, RAM port-B reads out,
// data+tag returned in order on a response stream, with credits sized to the response buffer.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned MEM_SIZE     = DEF_MEM_SIZE,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [MEM_SIZE-1:0]   req_addr,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  ram_enb,
    output logic [MEM_SIZE-1:0]   ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  busy
);

    localparam int unsigned FIFO_DEPTH = READ_LATENCY + 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    if (!rd_lat_legal(READ_LATENCY)) begin : g_bad_latency
        $error("bram_stream_reader: READ_LATENCY %0d outside %0d..%0d",
               READ_LATENCY, RD_LAT_MIN, RD_LAT_MAX);
    end
    if ((DATA_WIDTH != DEF_DATA_WIDTH) || (TAG_WIDTH != DEF_TAG_WIDTH)) begin : g_bad_width
        $error("bram_stream_reader: widths must match rsp_t in bram_stream_reader_pkg");
    end

    logic                  fire;
    logic                  push;
    logic                  pop;
    logic [READ_LATENCY-1:0] stg_vld_q, stg_vld_d;
    logic [TAG_WIDTH-1:0]  stg_tag_q [READ_LATENCY];
    logic [TAG_WIDTH-1:0]  stg_tag_d [READ_LATENCY];
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_count_nxt;
    logic [CNT_W-1:0]      occupancy_nxt;
    logic                  req_ready_q, req_ready_d;
    logic                  busy_q, busy_d;
    rsp_t                  push_entry;
    rsp_t                  head_entry;

    assign fire      = req_valid && req_ready_q;
    assign ram_enb   = fire;
    assign ram_addrb = req_addr;
    assign push      = stg_vld_q[READ_LATENCY-1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;

    // Latency shadow pipeline plus credit bookkeeping; req_ready/busy are registered
    // from next-state occupancy so no input reaches them combinationally.
    always_comb begin
        stg_vld_d    = '0;
        stg_tag_d    = stg_tag_q;
        stg_vld_d[0] = fire;
        stg_tag_d[0] = req_tag;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            stg_vld_d[i] = stg_vld_q[i-1];
            stg_tag_d[i] = stg_tag_q[i-1];
        end
        push_entry.data = ram_dob;
        push_entry.tag  = stg_tag_q[READ_LATENCY-1];
        inflight_d      = inflight_q + CNT_W'(fire) - CNT_W'(push);
        fifo_count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);
        occupancy_nxt   = inflight_d + fifo_count_nxt;
        req_ready_d     = (occupancy_nxt < CNT_W'(FIFO_DEPTH));
        busy_d          = (occupancy_nxt != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld_q <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                stg_tag_q[i] <= '0;
            end
            inflight_q  <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            stg_vld_q   <= stg_vld_d;
            stg_tag_q   <= stg_tag_d;
            inflight_q  <= inflight_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    small_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_t))
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (fifo_count)
    );

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_data  = head_entry.data;
    assign rsp_tag   = head_entry.tag;

endmodule
